// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one imem read at a time,
// holds one response across a decode stall, and squashes on redirect.
// Ports: clk/rst (sync, active-high); stall, redirect_valid/redirect_pc in;
// imem_addr/imem_rmask out, imem_resp/imem_rdata in;
// id_resp/id_rdata to decode; if_id_reg registered pc/pc_next/valid.

typedef struct packed {
    logic [31:0] pc_s;
    logic [31:0] pc_next_s;
    logic        valid_s;
} if_id_stage_reg_t;

module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      imem_addr,
    output logic [3:0]       imem_rmask,
    input  logic             imem_resp,
    input  logic [31:0]      imem_rdata,
    output logic             id_resp,
    output logic [31:0]      id_rdata,
    output if_id_stage_reg_t if_id_reg
);

    typedef enum logic [1:0] {
        ISSUE,
        WAIT,
        HOLD
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             drop_q, drop_d;
    logic [31:0]      buf_q, buf_d;
    if_id_stage_reg_t if_id_q, if_id_d;
    logic             deliver;
    logic [31:0]      pc_inc;

    assign pc_inc     = pc_q + 32'd4;
    assign imem_addr  = pc_q;
    assign imem_rmask = (state_q == ISSUE && !redirect_valid) ? 4'hf : 4'h0;
    assign id_rdata   = (state_q == HOLD) ? buf_q : imem_rdata;
    assign id_resp    = deliver;
    assign if_id_reg  = if_id_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        buf_d   = buf_q;
        if_id_d = if_id_q;
        deliver = 1'b0;
        if (redirect_valid) begin
            pc_d = redirect_pc;
            if_id_d.valid_s = 1'b0;
            unique case (state_q)
                ISSUE: state_d = ISSUE;
                WAIT: begin
                    if (imem_resp) begin
                        state_d = ISSUE;
                        drop_d  = 1'b0;
                    end else begin
                        // Outstanding read belongs to the old path.
                        drop_d = 1'b1;
                    end
                end
                HOLD: state_d = ISSUE;
                default: state_d = ISSUE;
            endcase
        end else begin
            unique case (state_q)
                ISSUE: state_d = WAIT;
                WAIT: begin
                    if (imem_resp) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = ISSUE;
                        end else if (!stall) begin
                            deliver = 1'b1;
                            if_id_d = '{pc_q, pc_inc, 1'b1};
                            pc_d    = pc_inc;
                            state_d = ISSUE;
                        end else begin
                            buf_d   = imem_rdata;
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        deliver = 1'b1;
                        if_id_d = '{pc_q, pc_inc, 1'b1};
                        pc_d    = pc_inc;
                        state_d = ISSUE;
                    end
                end
                default: state_d = ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ISSUE;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            buf_q   <= 32'd0;
            if_id_q <= '{32'd0, 32'd0, 1'b0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            buf_q   <= buf_d;
            if_id_q <= if_id_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized
// run scored against a PC/instruction-stream reference model.

module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h1eceb000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        id_resp;
    logic [31:0] id_rdata;
    logic [64:0] if_id_bits;

    int errors = 0;
    int checks = 0;

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_addr     (imem_addr),
        .imem_rmask    (imem_rmask),
        .imem_resp     (imem_resp),
        .imem_rdata    (imem_rdata),
        .id_resp       (id_resp),
        .id_rdata      (id_rdata),
        .if_id_reg     (if_id_bits)
    );

    always #5 clk = ~clk;

    wire [31:0] ifid_pc   = if_id_bits[64:33];
    wire [31:0] ifid_next = if_id_bits[32:1];
    wire        ifid_v    = if_id_bits[0];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0013_5a13;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        imem_resp = 1'b0;
        imem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        imem_resp = 1'b0;
        imem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (imem_addr !== RST_PC) begin
            errors++;
            $display("FAIL reset_addr got=%h exp=%h", imem_addr, RST_PC);
        end
        checks++;
        if (if_id_bits !== 65'd0) begin
            errors++;
            $display("FAIL reset_ifid got=%h exp=0", if_id_bits);
        end
        checks++;
        if (id_resp !== 1'b0) begin
            errors++;
            $display("FAIL reset_idresp got=%b exp=0", id_resp);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_rmask !== 4'hf || imem_addr !== RST_PC) begin
            errors++;
            $display("FAIL reset_first_req got=%h/%h exp=f/%h",
                     imem_rmask, imem_addr, RST_PC);
        end
    endtask

    task automatic test_free_run();
        logic [31:0] a;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            a = RST_PC + 32'(4 * i);
            @(negedge clk);
            checks++;
            if (imem_rmask !== 4'hf || imem_addr !== a) begin
                errors++;
                $display("FAIL free_req%0d got=%h/%h exp=f/%h",
                         i, imem_rmask, imem_addr, a);
            end
            if (i > 0) begin
                checks++;
                if (if_id_bits !== {a - 32'd4, a, 1'b1}) begin
                    errors++;
                    $display("FAIL free_ifid%0d got=%h exp=%h",
                             i, if_id_bits, {a - 32'd4, a, 1'b1});
                end
            end
            next_cycle();
            imem_resp = 1'b1;
            imem_rdata = inst_of(a);
            @(negedge clk);
            checks++;
            if (id_resp !== 1'b1 || id_rdata !== inst_of(a)
                || imem_rmask !== 4'h0) begin
                errors++;
                $display("FAIL free_dlv%0d got=%b/%h/%h exp=1/%h/0",
                         i, id_resp, id_rdata, imem_rmask, inst_of(a));
            end
            next_cycle();
            imem_resp = 1'b0;
        end
    endtask

    task automatic test_stall_hold();
        do_reset();
        next_cycle();
        stall = 1'b1;
        imem_resp = 1'b1;
        imem_rdata = 32'h00000013;
        @(negedge clk);
        checks++;
        if (id_resp !== 1'b0) begin
            errors++;
            $display("FAIL stall_resp got=%b exp=0", id_resp);
        end
        next_cycle();
        imem_resp = 1'b0;
        imem_rdata = 32'hbad0bad0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (id_resp !== 1'b0 || imem_rmask !== 4'h0) begin
                errors++;
                $display("FAIL stall_hold%0d got=%b/%h exp=0/0",
                         i, id_resp, imem_rmask);
            end
            next_cycle();
        end
        stall = 1'b0;
        @(negedge clk);
        checks++;
        if (id_resp !== 1'b1 || id_rdata !== 32'h00000013) begin
            errors++;
            $display("FAIL stall_release got=%b/%h exp=1/00000013",
                     id_resp, id_rdata);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (imem_rmask !== 4'hf || imem_addr !== RST_PC + 32'd4) begin
            errors++;
            $display("FAIL stall_next_req got=%h/%h exp=f/%h",
                     imem_rmask, imem_addr, RST_PC + 32'd4);
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc = 32'h1eceb100;
        @(negedge clk);
        checks++;
        if (id_resp !== 1'b0 || imem_rmask !== 4'h0) begin
            errors++;
            $display("FAIL rdw_cycle got=%b/%h exp=0/0", id_resp, imem_rmask);
        end
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_rmask !== 4'h0 || ifid_v !== 1'b0) begin
            errors++;
            $display("FAIL rdw_wait got=%h/%b exp=0/0", imem_rmask, ifid_v);
        end
        next_cycle();
        imem_resp = 1'b1;
        imem_rdata = 32'hdeadbeef;
        @(negedge clk);
        checks++;
        if (id_resp !== 1'b0) begin
            errors++;
            $display("FAIL rdw_drop got=%b exp=0", id_resp);
        end
        next_cycle();
        imem_resp = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_rmask !== 4'hf || imem_addr !== 32'h1eceb100
            || ifid_v !== 1'b0) begin
            errors++;
            $display("FAIL rdw_req got=%h/%h/%b exp=f/1eceb100/0",
                     imem_rmask, imem_addr, ifid_v);
        end
        next_cycle();
        imem_resp = 1'b1;
        imem_rdata = 32'h00000013;
        @(negedge clk);
        checks++;
        if (id_resp !== 1'b1 || id_rdata !== 32'h00000013) begin
            errors++;
            $display("FAIL rdw_dlv got=%b/%h exp=1/00000013",
                     id_resp, id_rdata);
        end
        next_cycle();
        imem_resp = 1'b0;
        @(negedge clk);
        checks++;
        if (ifid_v !== 1'b1 || ifid_pc !== 32'h1eceb100) begin
            errors++;
            $display("FAIL rdw_ifid got=%b/%h exp=1/1eceb100",
                     ifid_v, ifid_pc);
        end
    endtask

    task automatic test_redirect_coincident();
        do_reset();
        next_cycle();
        imem_resp = 1'b1;
        imem_rdata = 32'h12345678;
        redirect_valid = 1'b1;
        redirect_pc = 32'h1eceb200;
        @(negedge clk);
        checks++;
        if (id_resp !== 1'b0) begin
            errors++;
            $display("FAIL coinc_resp got=%b exp=0", id_resp);
        end
        next_cycle();
        imem_resp = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_rmask !== 4'hf || imem_addr !== 32'h1eceb200) begin
            errors++;
            $display("FAIL coinc_req got=%h/%h exp=f/1eceb200",
                     imem_rmask, imem_addr);
        end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 32'hfffffffc;
        @(negedge clk);
        checks++;
        if (imem_rmask !== 4'h0) begin
            errors++;
            $display("FAIL wrap_suppress got=%h exp=0", imem_rmask);
        end
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_rmask !== 4'hf || imem_addr !== 32'hfffffffc) begin
            errors++;
            $display("FAIL wrap_req got=%h/%h exp=f/fffffffc",
                     imem_rmask, imem_addr);
        end
        next_cycle();
        imem_resp = 1'b1;
        imem_rdata = 32'h0000006f;
        @(negedge clk);
        checks++;
        if (id_resp !== 1'b1) begin
            errors++;
            $display("FAIL wrap_dlv got=%b exp=1", id_resp);
        end
        next_cycle();
        imem_resp = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_rmask !== 4'hf || imem_addr !== 32'h0
            || ifid_next !== 32'h0 || ifid_pc !== 32'hfffffffc) begin
            errors++;
            $display("FAIL wrap_next got=%h/%h/%h/%h exp=f/0/0/fffffffc",
                     imem_rmask, imem_addr, ifid_next, ifid_pc);
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        next_cycle();
        imem_resp = 1'b1;
        imem_rdata = 32'h11111111;
        next_cycle();
        imem_resp = 1'b0;
        next_cycle();
        rst = 1'b1;
        imem_resp = 1'b1;
        imem_rdata = 32'h22222222;
        next_cycle();
        rst = 1'b0;
        imem_resp = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_rmask !== 4'hf || imem_addr !== RST_PC) begin
            errors++;
            $display("FAIL rstmid_req got=%h/%h exp=f/%h",
                     imem_rmask, imem_addr, RST_PC);
        end
        checks++;
        if (if_id_bits !== 65'd0 || id_resp !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_out got=%h/%b exp=0/0", if_id_bits, id_resp);
        end
        next_cycle();
        imem_resp = 1'b1;
        imem_rdata = 32'h33333333;
        @(negedge clk);
        checks++;
        if (id_resp !== 1'b1 || id_rdata !== 32'h33333333) begin
            errors++;
            $display("FAIL rstmid_dlv got=%b/%h exp=1/33333333",
                     id_resp, id_rdata);
        end
        next_cycle();
        imem_resp = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] last_pc;
        logic        exp_v;
        logic        nv;
        logic        pend;
        int          cnt;
        logic [31:0] maddr;
        int          idle;
        int          dlv;
        do_reset();
        exp_pc = RST_PC;
        last_pc = 32'd0;
        exp_v = 1'b0;
        pend = 1'b0;
        cnt = 0;
        maddr = 32'd0;
        idle = 0;
        dlv = 0;
        for (int c = 0; c < 3000; c++) begin
            imem_resp = 1'b0;
            imem_rdata = $urandom;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_resp = 1'b1;
                    imem_rdata = inst_of(maddr);
                    pend = 1'b0;
                end
            end
            stall = ($urandom_range(9) < 3);
            redirect_valid = ($urandom_range(31) == 0);
            redirect_pc = $urandom & 32'hfffffffc;
            @(negedge clk);
            nv = exp_v;
            checks++;
            if (ifid_v !== exp_v || (exp_v
                && (ifid_pc !== last_pc || ifid_next !== last_pc + 32'd4))) begin
                errors++;
                $display("FAIL rnd_ifid c=%0d got=%h exp_v=%b pc=%h",
                         c, if_id_bits, exp_v, last_pc);
            end
            if (id_resp === 1'b1) begin
                checks++;
                if (stall || redirect_valid || id_rdata !== inst_of(exp_pc)) begin
                    errors++;
                    $display("FAIL rnd_dlv c=%0d got=%h exp=%h st=%b rd=%b",
                             c, id_rdata, inst_of(exp_pc), stall, redirect_valid);
                end
                last_pc = exp_pc;
                exp_pc = exp_pc + 32'd4;
                nv = 1'b1;
                dlv++;
            end
            if (redirect_valid) begin
                exp_pc = redirect_pc;
                nv = 1'b0;
            end
            if (imem_rmask === 4'hf) begin
                checks++;
                if (pend || imem_addr !== exp_pc) begin
                    errors++;
                    $display("FAIL rnd_req c=%0d got=%h exp=%h busy=%b",
                             c, imem_addr, exp_pc, pend);
                end
                pend = 1'b1;
                cnt = $urandom_range(3, 1);
                maddr = imem_addr;
            end
            if (id_resp === 1'b1 || imem_rmask !== 4'h0 || redirect_valid)
                idle = 0;
            else
                idle++;
            checks++;
            if (idle > 24) begin
                errors++;
                $display("FAIL rnd_stuck c=%0d idle=%0d", c, idle);
                idle = 0;
            end
            exp_v = nv;
            next_cycle();
        end
        checks++;
        if (dlv < 300) begin
            errors++;
            $display("FAIL rnd_throughput got=%0d exp>=300", dlv);
        end
        stall = 1'b0;
        redirect_valid = 1'b0;
        imem_resp = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall_hold();
        test_redirect_wait();
        test_redirect_coincident();
        test_pc_wrap();
        test_rst_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
